// File: rtl/klein_serial_io.sv
// klein_serial_io
// Byte-serial sequencer wrapped around the KLEIN 8-bit round datapath.
// It accepts a plaintext/key pair and streams both into the datapath one byte
// per cycle, with the load strobe asserted. It then waits out the fixed core
// latency, collects the ciphertext bytes from core_out, and holds the
// assembled word until the consumer takes it.
// Byte i of every bus occupies bits [8i:8i+7]. Byte 0 is the most significant
// byte and is always the first one on the wire.

module klein_serial_io #(
    parameter int BLK_BYTES   = 8,
    parameter int KEY_BYTES   = 10,
    parameter int CORE_CYCLES = 192
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:8*BLK_BYTES-1]   pt,
    input  logic [0:8*KEY_BYTES-1]   key,
    output logic [0:7]               core_inp,
    output logic [0:7]               core_key,
    output logic                     core_load,
    input  logic [0:7]               core_out,
    output logic [0:8*BLK_BYTES-1]   ct,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PT_W    = 8 * BLK_BYTES;
    localparam int KEY_W   = 8 * KEY_BYTES;
    localparam int CNT_MAX = (KEY_BYTES > CORE_CYCLES) ? KEY_BYTES : CORE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts. UNLOAD collects the bytes after byte 0, so it ends
    // two short of BLK_BYTES. With a one-byte block it is skipped entirely.
    localparam logic [CNT_W-1:0] LAST_LOAD   = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_RUN    = CNT_W'(CORE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_UNLOAD = CNT_W'((BLK_BYTES >= 2) ? (BLK_BYTES - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_UNLOAD = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    // Byte 0 is captured on the final RUN edge. A one-byte block is therefore
    // already complete at that point.
    localparam logic [2:0] S_AFTER_RUN = (BLK_BYTES > 1) ? S_UNLOAD : S_HOLD;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [0:PT_W-1]   r_pt_sh;
    logic [0:KEY_W-1]  r_key_sh;
    logic [0:PT_W-1]   r_ct;
    logic [0:PT_W-1]   w_ct_shift;

    logic              w_accept;
    logic              w_capture;

    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_core_load;
    logic [0:7]        r_core_inp;
    logic [0:7]        r_core_key;

    logic              w_core_load_nxt;
    logic [0:7]        w_core_inp_nxt;
    logic [0:7]        w_core_key_nxt;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_capture  = ((r_state == S_RUN) && (r_cnt == LAST_RUN)) || (r_state == S_UNLOAD);
    assign w_ct_shift = (r_ct << 4'd8) | PT_W'(core_out);

    // Next-state and counter: the counter restarts on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_LOAD: begin
                if (r_cnt == LAST_LOAD) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_RUN) begin
                    w_state_nxt = S_AFTER_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_UNLOAD: begin
                if (r_cnt == LAST_UNLOAD) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_UNLOAD;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Bytes that appear on the datapath in the coming cycle. On the accept
    // edge, byte 0 comes straight from the input ports. After that it comes
    // from the head of the shift registers. The plaintext register fills with
    // zeros, so a key longer than the block pads core_inp automatically.
    always_comb begin
        w_core_load_nxt = 1'b0;
        w_core_inp_nxt  = 8'h00;
        w_core_key_nxt  = 8'h00;
        if (w_state_nxt == S_LOAD) begin
            w_core_load_nxt = 1'b1;
            if (r_state == S_IDLE) begin
                w_core_inp_nxt = pt[0 +: 8];
                w_core_key_nxt = key[0 +: 8];
            end else begin
                w_core_inp_nxt = r_pt_sh[0 +: 8];
                w_core_key_nxt = r_key_sh[0 +: 8];
            end
        end else begin
            w_core_load_nxt = 1'b0;
            w_core_inp_nxt  = 8'h00;
            w_core_key_nxt  = 8'h00;
        end
    end

    // State and counter registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Input shift registers: byte 0 leaves directly from the ports on the
    // accept edge, and the remaining bytes move up one slot per LOAD cycle.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_pt_sh  <= {PT_W{1'b0}};
            r_key_sh <= {KEY_W{1'b0}};
        end else if (w_accept) begin
            r_pt_sh  <= pt << 4'd8;
            r_key_sh <= key << 4'd8;
        end else if (r_state == S_LOAD) begin
            r_pt_sh  <= r_pt_sh << 4'd8;
            r_key_sh <= r_key_sh << 4'd8;
        end else begin
            r_pt_sh  <= r_pt_sh;
            r_key_sh <= r_key_sh;
        end
    end

    // Ciphertext assembly: core_out enters the low byte unregistered, so byte
    // 0 ends up in the most significant position after the last capture.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_ct <= {PT_W{1'b0}};
        end else if (w_capture) begin
            r_ct <= w_ct_shift;
        end else begin
            r_ct <= r_ct;
        end
    end

    // Handshake and datapath-facing outputs are all registered copies of the
    // next-state decode, so every output is glitch-free.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_core_load <= 1'b0;
            r_core_inp  <= 8'h00;
            r_core_key  <= 8'h00;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_HOLD);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_core_load <= w_core_load_nxt;
            r_core_inp  <= w_core_inp_nxt;
            r_core_key  <= w_core_key_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign core_load = r_core_load;
    assign core_inp  = r_core_inp;
    assign core_key  = r_core_key;
    assign ct        = r_ct;

endmodule

// File: doc/klein_serial_io.md
Name: klein_serial_io

Overview:
Byte-serial I/O sequencer that sits directly upstream and downstream of the KLEIN 8-bit serial round datapath.
- Accepts one 64-bit plaintext block and one 80-bit key over a valid/ready handshake.
- Streams both to the datapath one byte per cycle, with the load strobe that drives the datapath's round0 select.
- Waits a fixed core latency, then captures the datapath's 8-bit output stream and presents it as a 64-bit ciphertext word, held until the consumer accepts it.

Parameters:
BLK_BYTES, 8, bytes per data block.
KEY_BYTES, 10, bytes per key; must be >= BLK_BYTES.
CORE_CYCLES, 192, cycles from the first RUN cycle to the first valid output byte on core_out; minimum 1.

Ports:
ck  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  plaintext/key offered
in_ready  output  1  block can accept plaintext/key
pt  input  [0:8*BLK_BYTES-1]  plaintext, bit 0 = MSB
key  input  [0:8*KEY_BYTES-1]  key, bit 0 = MSB
core_inp  output  [0:7]  plaintext byte to datapath inp
core_key  output  [0:7]  key byte to datapath key
core_load  output  1  load strobe, drives datapath round0
core_out  input  [0:7]  datapath out byte
ct  output  [0:8*BLK_BYTES-1]  ciphertext, bit 0 = MSB
out_valid  output  1  ct valid
out_ready  input  1  consumer accepts ct
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: when rst is high at a clock edge, the FSM goes to IDLE and all counters clear. Outputs after that edge: in_ready=1, out_valid=0, busy=0, core_load=0, core_inp=0, core_key=0, ct=0.
- Reset mid-operation has the same effect. Any partial load or capture is discarded.
- Byte order: byte i occupies bits [8i:8i+7]. Byte 0 (MSB) is sent and captured first.
- FSM states: IDLE, LOAD, RUN, UNLOAD, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch pt and key into internal shift registers, clear the byte counter, and go to LOAD.
  - pt and key may change after the accepting edge.
- LOAD (exactly KEY_BYTES cycles):
  - core_load=1.
  - core_key = key byte n, where n is the byte counter 0..KEY_BYTES-1.
  - core_inp = pt byte n for n < BLK_BYTES; core_inp = 8'h00 for n >= BLK_BYTES.
  - Both shift registers shift left by one byte per cycle.
  - When n = KEY_BYTES-1, clear the counter and go to RUN.
- RUN:
  - core_load=0; core_inp=0; core_key=0.
  - The counter counts CORE_CYCLES cycles.
  - The last RUN cycle is the one in which core_out carries ciphertext byte 0. The FSM goes to UNLOAD with byte 0 captured on that edge.
  - With CORE_CYCLES=1, byte 0 is captured on the first RUN edge.
- UNLOAD:
  - Capture one core_out byte per cycle into the ct shift register (shift left, insert at LSB byte).
  - After BLK_BYTES bytes in total have been captured, go to HOLD.
  - UNLOAD therefore lasts BLK_BYTES-1 cycles.
  - core_out is sampled with no additional register stage.
- HOLD:
  - out_valid=1 and ct is stable.
  - On out_ready=1, go to IDLE.
  - out_valid deasserts and in_ready asserts on the same edge.
  - No overlap: a new block is accepted only in IDLE, so a back-to-back transfer costs one IDLE cycle.
- Latency: accept edge to out_valid = KEY_BYTES + CORE_CYCLES + BLK_BYTES - 1 cycles. Default 10+192+7 = 209.
- busy=1 in LOAD, RUN, UNLOAD and HOLD.
- Ignored inputs:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside HOLD.
  - out_ready held high continuously gives out_valid high for exactly one cycle.
- Counters: width clog2(max(KEY_BYTES, CORE_CYCLES) + 1). Counters do not wrap within a state; they clear on every state change.
- Simultaneous events:
  - rst has priority over every handshake.
  - in_valid and out_ready asserted together in HOLD: only the out_ready transfer takes effect.

Test Plan:
1. Reset/idle: assert rst for 2 cycles mid-RUN -> next cycle in_ready=1, busy=0, out_valid=0, ct=0, core_load=0; no capture follows.
2. Load sequencing: pt=64'h0123456789ABCDEF, key=80'h00112233445566778899, in_valid for one cycle ->
   - core_load=1 for exactly 10 cycles;
   - core_inp = 01,23,45,67,89,AB,CD,EF,00,00;
   - core_key = 00,11,...,99.
3. Capture/latency: stub core_out to drive A0+k on the k-th UNLOAD-relevant cycle (byte 0 on the last RUN cycle) -> ct=64'hA0A1A2A3A4A5A6A7; out_valid rises 209 cycles after the accept edge.
4. Backpressure: hold out_ready=0 for 50 cycles in HOLD -> ct and out_valid stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
5. Back-to-back: in_valid and out_ready held high, two blocks -> the second accept occurs exactly one cycle after the first out_valid/out_ready edge; both ct values are correct.
6. Parameter corner: CORE_CYCLES=1, KEY_BYTES=BLK_BYTES=8 -> core_inp is never padded with 00; latency = 8+1+7 = 16 cycles.
